// File: rtl/traffic_ctrl_if.sv
// Pedestrian request and light outputs of the intersection controller.
// The controller side uses the slave modport; the requester/observer side uses master.
interface traffic_ctrl_if;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;

  modport master (
    output ped_req,
    input  ns_light,
    input  ew_light,
    input  walk,
    input  ped_ack
  );

  modport slave (
    input  ped_req,
    output ns_light,
    output ew_light,
    output walk,
    output ped_ack
  );
endinterface

// File: rtl/traffic_ctrl.sv
// Two-road intersection sequencer with a pedestrian walk phase.
// Moore FSM plus a down-counting dwell timer; all outputs are decoded from registers only.
module traffic_ctrl #(
  parameter int unsigned T_GREEN  = 8,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_WALK   = 5
) (
  input logic           clk,
  input logic           rst,
  traffic_ctrl_if.slave bus
);

  localparam int unsigned TMAX_A = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int unsigned TMAX_B = (T_ALLRED > T_WALK) ? T_ALLRED : T_WALK;
  localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] LD_GREEN  = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] LD_YELLOW = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] LD_ALLRED = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] LD_WALK   = TW'(T_WALK - 1);

  localparam logic [2:0] NS_G = 3'd0;
  localparam logic [2:0] NS_Y = 3'd1;
  localparam logic [2:0] AR_A = 3'd2;
  localparam logic [2:0] EW_G = 3'd3;
  localparam logic [2:0] EW_Y = 3'd4;
  localparam logic [2:0] AR_B = 3'd5;
  localparam logic [2:0] WALK = 3'd6;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic          expired;

  assign expired = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q - TW'(1);
    // A request seen in the AR_B decision cycle is folded in so it is served this rotation.
    pend_d  = pend_q | (bus.ped_req & (state_q != WALK));
    case (state_q)
      NS_G: if (expired) begin state_d = NS_Y; timer_d = LD_YELLOW; end
      NS_Y: if (expired) begin state_d = AR_A; timer_d = LD_ALLRED; end
      AR_A: if (expired) begin state_d = EW_G; timer_d = LD_GREEN;  end
      EW_G: if (expired) begin state_d = EW_Y; timer_d = LD_YELLOW; end
      EW_Y: if (expired) begin state_d = AR_B; timer_d = LD_ALLRED; end
      AR_B: begin
        if (expired) begin
          if (pend_d) begin
            state_d = WALK;
            timer_d = LD_WALK;
            pend_d  = 1'b0;
          end else begin
            state_d = NS_G;
            timer_d = LD_GREEN;
          end
        end
      end
      WALK: if (expired) begin state_d = NS_G; timer_d = LD_GREEN; end
      default: begin
        state_d = NS_G;
        timer_d = LD_GREEN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NS_G;
      timer_q <= LD_GREEN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    bus.ns_light = RED;
    bus.ew_light = RED;
    bus.walk     = 1'b0;
    bus.ped_ack  = 1'b0;
    case (state_q)
      NS_G: bus.ns_light = GRN;
      NS_Y: bus.ns_light = YEL;
      EW_G: bus.ew_light = GRN;
      EW_Y: bus.ew_light = YEL;
      WALK: begin
        bus.walk    = 1'b1;
        // The timer still holds its load value only in the first WALK cycle.
        bus.ped_ack = (timer_q == LD_WALK);
      end
      default: ;
    endcase
  end

endmodule
